pipe_bus_bridge: RTL



---
 rtl/pipe_bus_pkg.sv | 14 +
 rtl/pipe_bus_watchdog.sv | 41 ++++
 rtl/pipe_bus_bridge.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pipe_bus_pkg.sv
// Shared types and constants for the CPU-to-Avalon memory bridge.
package pipe_bus_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUS  = 1'b1
   } bus_state_t;

   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1023;

   // Bus addresses are always word aligned; the low two bits are dropped.
   localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/pipe_bus_watchdog.sv
// Wait-state watchdog: counts stalled bus cycles and flags the cycle whose
// edge would bring the count up to TIMEOUT_CYCLES.
module pipe_bus_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: clear on entry to a transfer, otherwise advance per wait cycle.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count_en) begin
         count_d = count_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Expiry only while waiting, so a waitrequest drop on the same edge wins.
   assign expired = count_en && (count_q == LAST);

endmodule

// File: rtl/pipe_bus_bridge.sv
// Bridge from the CPU memory-stage request port to an Avalon-style bus.
// States:
//   IDLE | no transfer outstanding, accepting CPU requests
//   BUS  | transfer held on the bus until waitrequest drops or watchdog fires
module pipe_bus_bridge
   import pipe_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [31:0] cpu_address,
   input  logic [31:0] cpu_writedata,
   input  logic [3:0]  cpu_byteenable,
   output logic        cpu_stall,
   output logic [31:0] cpu_readdata,
   output logic        cpu_readvalid,
   output logic        bus_error,
   output logic        read,
   output logic        write,
   output logic [31:0] address,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic        waitrequest,
   input  logic [31:0] readdata
);

   bus_state_t  state_q, state_d;
   logic        read_q, read_d;
   logic        write_q, write_d;
   logic [31:0] address_q, address_d;
   logic [31:0] writedata_q, writedata_d;
   logic [3:0]  byteenable_q, byteenable_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rvalid_q, rvalid_d;
   logic        err_q, err_d;
   logic        wd_clear;
   logic        wd_en;
   logic        wd_expired;

   pipe_bus_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .reset    (reset),
      .clear    (wd_clear),
      .count_en (wd_en),
      .expired  (wd_expired)
   );

   // Next-state, hold-register and response logic.
   always_comb begin
      state_d      = state_q;
      read_d       = read_q;
      write_d      = write_q;
      address_d    = address_q;
      writedata_d  = writedata_q;
      byteenable_d = byteenable_q;
      rdata_d      = rdata_q;
      rvalid_d     = 1'b0;
      err_d        = err_q;
      wd_clear     = 1'b0;
      wd_en        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cpu_read ^ cpu_write) begin
               address_d    = cpu_address & WORD_ALIGN_MASK;
               writedata_d  = cpu_writedata;
               byteenable_d = cpu_byteenable;
               read_d       = cpu_read;
               write_d      = cpu_write;
               wd_clear     = 1'b1;
               state_d      = BUS;
               if (cpu_address[1:0] != 2'b00) begin
                  err_d = 1'b1;
               end
            end else if (cpu_read && cpu_write) begin
               err_d = 1'b1;
            end
         end
         BUS: begin
            if (!waitrequest) begin
               state_d = IDLE;
               read_d  = 1'b0;
               write_d = 1'b0;
               if (read_q) begin
                  rdata_d  = readdata;
                  rvalid_d = 1'b1;
               end
            end else begin
               wd_en = 1'b1;
               if (wd_expired) begin
                  // Aborted reads still return (zero) data so the pipeline unfreezes.
                  state_d = IDLE;
                  read_d  = 1'b0;
                  write_d = 1'b0;
                  err_d   = 1'b1;
                  if (read_q) begin
                     rdata_d  = '0;
                     rvalid_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         address_q    <= '0;
         writedata_q  <= '0;
         byteenable_q <= '0;
         rdata_q      <= '0;
         rvalid_q     <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         read_q       <= read_d;
         write_q      <= write_d;
         address_q    <= address_d;
         writedata_q  <= writedata_d;
         byteenable_q <= byteenable_d;
         rdata_q      <= rdata_d;
         rvalid_q     <= rvalid_d;
         err_q        <= err_d;
      end
   end

   assign cpu_stall     = (state_q == BUS);
   assign cpu_readdata  = rdata_q;
   assign cpu_readvalid = rvalid_q;
   assign bus_error     = err_q;
   assign read          = read_q;
   assign write         = write_q;
   assign address       = address_q;
   assign writedata     = writedata_q;
   assign byteenable    = byteenable_q;

endmodule
